// File: rtl/mem_arb_pkg.sv
// Shared types for the memory-port arbiter: requester id, dispatch opcode and dispatch record.
package mem_arb_pkg;
    localparam int NUM_REQ_DEF = 2;
    localparam int ADDR_W_DEF  = 16;
    localparam int DATA_W_DEF  = 8;

    typedef logic [$clog2(NUM_REQ_DEF)-1:0] req_id_t;

    typedef enum logic [1:0] {
        OP_NONE,
        OP_READ,
        OP_WRITE
    } mem_op_e;

    typedef struct packed {
        mem_op_e                 op;
        logic [ADDR_W_DEF-1:0]   addr;
        logic [DATA_W_DEF-1:0]   data;
    } dispatch_t;
endpackage

// File: rtl/mem_bus_arbiter_rr_picker.sv
// Round-robin select: first requester at or after i_ptr (cyclic) wins.
// Purely combinational; one-hot grant plus encoded id and any flag.
module rr_picker #(
    parameter int N   = 2,
    parameter int IDW = 1
) (
    input  logic [N-1:0]   i_req,
    input  logic [IDW-1:0] i_ptr,
    output logic [N-1:0]   o_grant,
    output logic [IDW-1:0] o_id,
    output logic           o_any
);
    int w_idx;

    always_comb begin
        o_grant = '0;
        o_id    = '0;
        o_any   = 1'b0;
        w_idx   = 0;
        for (int k = 0; k < N; k++) begin
            w_idx = (int'(i_ptr) + k) % N;
            if (!o_any && i_req[w_idx]) begin
                o_any          = 1'b1;
                o_id           = IDW'(w_idx);
                o_grant[w_idx] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one registered memory dispatch slot among NUM_REQ requesters;
// read data returns READ_LATENCY cycles after dispatch acceptance and is steered by a tag pipeline.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ      = 2,
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 8,
    parameter int READ_LATENCY = 2
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic [NUM_REQ-1:0]        req_read_in,
    input  logic [NUM_REQ-1:0]        req_write_in,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr_in,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata_in,
    output logic [NUM_REQ-1:0]        req_accept_out,
    output logic [NUM_REQ-1:0]        rsp_valid_out,
    output logic [DATA_W-1:0]         rsp_data_out,
    output logic [ADDR_W-1:0]         mem_addr_out,
    output logic [DATA_W-1:0]         mem_write_data_out,
    output logic                      mem_dispatch_read_out,
    output logic                      mem_dispatch_write_out,
    input  logic                      mem_ready_in,
    input  logic [DATA_W-1:0]         mem_read_data_in
);
    localparam int IDW = $clog2(NUM_REQ);

    logic [IDW-1:0]    r_ptr;
    mem_op_e           r_op;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic [IDW-1:0]    r_id;

    logic [READ_LATENCY-1:0] r_tag_vld;
    logic [IDW-1:0]          r_tag_id [READ_LATENCY];

    logic               w_can_load;
    logic               w_rd_fire;
    logic [NUM_REQ-1:0] w_pick_req;
    logic [NUM_REQ-1:0] w_grant;
    logic [IDW-1:0]     w_id;
    logic               w_any;
    logic               w_win_wr;

    // The slot may refill in the same cycle memory takes its current contents.
    assign w_can_load = (r_op == OP_NONE) || mem_ready_in;
    assign w_rd_fire  = (r_op == OP_READ) && mem_ready_in;
    assign w_pick_req = (w_can_load && !rst_in) ? (req_read_in | req_write_in) : '0;
    assign w_win_wr   = |(req_write_in & w_grant);

    rr_picker #(
        .N   (NUM_REQ),
        .IDW (IDW)
    ) u_picker (
        .i_req   (w_pick_req),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_id    (w_id),
        .o_any   (w_any)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_ptr     <= '0;
            r_op      <= OP_NONE;
            r_addr    <= '0;
            r_data    <= '0;
            r_id      <= '0;
            r_tag_vld <= '0;
            for (int s = 0; s < READ_LATENCY; s++) begin
                r_tag_id[s] <= '0;
            end
        end else begin
            if (w_can_load) begin
                if (w_any) begin
                    // A simultaneous read+write from one requester is taken as a write.
                    r_op   <= w_win_wr ? OP_WRITE : OP_READ;
                    r_addr <= req_addr_in[w_id*ADDR_W +: ADDR_W];
                    r_data <= req_wdata_in[w_id*DATA_W +: DATA_W];
                    r_id   <= w_id;
                    r_ptr  <= (w_id == IDW'(NUM_REQ-1)) ? '0 : w_id + IDW'(1);
                end else begin
                    r_op <= OP_NONE;
                end
            end
            for (int s = READ_LATENCY-1; s > 0; s--) begin
                r_tag_vld[s] <= r_tag_vld[s-1];
                r_tag_id[s]  <= r_tag_id[s-1];
            end
            r_tag_vld[0] <= w_rd_fire;
            r_tag_id[0]  <= r_id;
        end
    end

    always_comb begin
        rsp_valid_out = '0;
        if (r_tag_vld[READ_LATENCY-1]) begin
            rsp_valid_out[r_tag_id[READ_LATENCY-1]] = 1'b1;
        end
    end

    assign req_accept_out         = w_grant;
    assign rsp_data_out           = mem_read_data_in;
    assign mem_addr_out           = r_addr;
    assign mem_write_data_out     = r_data;
    assign mem_dispatch_read_out  = (r_op == OP_READ);
    assign mem_dispatch_write_out = (r_op == OP_WRITE);
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed cycle checks plus a response scoreboard fed by a memory model.
module tb_mem_bus_arbiter;
    localparam int NR = 2;
    localparam int AW = 16;
    localparam int DW = 8;
    localparam int RL = 2;

    logic             clk_in = 1'b0;
    logic             rst_in;
    logic [NR-1:0]    req_read_in;
    logic [NR-1:0]    req_write_in;
    logic [NR*AW-1:0] req_addr_in;
    logic [NR*DW-1:0] req_wdata_in;
    logic [NR-1:0]    req_accept_out;
    logic [NR-1:0]    rsp_valid_out;
    logic [DW-1:0]    rsp_data_out;
    logic [AW-1:0]    mem_addr_out;
    logic [DW-1:0]    mem_write_data_out;
    logic             mem_dispatch_read_out;
    logic             mem_dispatch_write_out;
    logic             mem_ready_in;
    logic [DW-1:0]    mem_read_data_in;

    mem_bus_arbiter #(
        .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(RL)
    ) dut (
        .clk_in                 (clk_in),
        .rst_in                 (rst_in),
        .req_read_in            (req_read_in),
        .req_write_in           (req_write_in),
        .req_addr_in            (req_addr_in),
        .req_wdata_in           (req_wdata_in),
        .req_accept_out         (req_accept_out),
        .rsp_valid_out          (rsp_valid_out),
        .rsp_data_out           (rsp_data_out),
        .mem_addr_out           (mem_addr_out),
        .mem_write_data_out     (mem_write_data_out),
        .mem_dispatch_read_out  (mem_dispatch_read_out),
        .mem_dispatch_write_out (mem_dispatch_write_out),
        .mem_ready_in           (mem_ready_in),
        .mem_read_data_in       (mem_read_data_in)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int         id;
        logic [7:0] dat;
    } exp_t;

    exp_t       sb_q[$];
    int         n_vec = 0;
    int         n_err = 0;
    int         cyc   = 0;
    logic       ret_vld [8];
    logic [7:0] ret_dat [8];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [7:0] memval(input logic [15:0] a);
        case (a)
            16'h0010: memval = 8'hA5;
            16'h0001: memval = 8'h33;
            16'h0002: memval = 8'h44;
            default:  memval = a[7:0] ^ 8'h5A;
        endcase
    endfunction

    // Memory model: a read taken in cycle c returns its data in cycle c+RL.
    always @(posedge clk_in) begin
        #1;
        cyc = cyc + 1;
        mem_read_data_in = ret_vld[cyc % 8] ? ret_dat[cyc % 8] : '0;
        ret_vld[cyc % 8] = 1'b0;
    end

    always @(negedge clk_in) begin
        if (mem_dispatch_read_out && mem_ready_in) begin
            ret_vld[(cyc + RL) % 8] = 1'b1;
            ret_dat[(cyc + RL) % 8] = memval(mem_addr_out);
        end
        if (rsp_valid_out != '0) begin
            if (sb_q.size() == 0) begin
                chk("rsp_spurious", 32'(rsp_valid_out), 32'h0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("rsp_id", 32'(rsp_valid_out), 32'(1) << e.id);
                chk("rsp_data", 32'(rsp_data_out), 32'(e.dat));
            end
        end
    end

    task automatic cyc_start();
        @(posedge clk_in);
        #1;
    endtask

    task automatic sample();
        @(negedge clk_in);
    endtask

    task automatic clr_req();
        req_read_in  = '0;
        req_write_in = '0;
    endtask

    task automatic set_req(input int id, input logic rd, input logic wr,
                           input logic [15:0] a, input logic [7:0] d);
        req_read_in[id]          = rd;
        req_write_in[id]         = wr;
        req_addr_in[id*AW +: AW] = a;
        req_wdata_in[id*DW +: DW] = d;
    endtask

    task automatic expect_rsp(input int id, input logic [15:0] a);
        exp_t e;
        e.id  = id;
        e.dat = memval(a);
        sb_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            cyc_start();
            clr_req();
            mem_ready_in = 1'b1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 8; i++) begin
            ret_vld[i] = 1'b0;
            ret_dat[i] = '0;
        end
        rst_in           = 1'b1;
        mem_ready_in     = 1'b1;
        mem_read_data_in = '0;
        req_addr_in      = '0;
        req_wdata_in     = '0;
        clr_req();

        // Reset: slot empty, no accepts even with requests present.
        for (int i = 0; i < 2; i++) begin
            cyc_start();
            req_write_in = 2'b11;
            sample();
            chk("rst_accept", 32'(req_accept_out), 32'h0);
            chk("rst_disp", {30'h0, mem_dispatch_read_out, mem_dispatch_write_out}, 32'h0);
            chk("rst_addr_data", {8'h0, mem_addr_out, mem_write_data_out}, 32'h0);
            chk("rst_rsp", 32'(rsp_valid_out), 32'h0);
        end

        cyc_start();
        rst_in = 1'b0;
        clr_req();
        for (int i = 0; i < 10; i++) begin
            sample();
            chk("idle_outputs", {18'h0, req_accept_out, rsp_valid_out, mem_dispatch_read_out,
                                 mem_dispatch_write_out, mem_addr_out == '0, mem_write_data_out == '0},
                32'h3);
            cyc_start();
        end

        // Two continuous writers alternate, starting from requester 0.
        set_req(0, 1'b0, 1'b1, 16'h0100, 8'h11);
        set_req(1, 1'b0, 1'b1, 16'h0200, 8'h22);
        for (int k = 0; k < 6; k++) begin
            sample();
            chk("wr_alt_accept", 32'(req_accept_out), (k % 2 == 0) ? 32'h1 : 32'h2);
            if (k > 0) begin
                chk("wr_alt_disp", {mem_dispatch_read_out, mem_dispatch_write_out, mem_addr_out, mem_write_data_out},
                    (k % 2 == 1) ? {2'b01, 16'h0100, 8'h11} : {2'b01, 16'h0200, 8'h22});
            end
            cyc_start();
        end
        clr_req();
        sample();
        chk("wr_last_accept", 32'(req_accept_out), 32'h0);
        chk("wr_last_disp", {mem_dispatch_write_out, mem_addr_out, mem_write_data_out}, {1'b1, 16'h0200, 8'h22});
        cyc_start();
        sample();
        chk("wr_slot_empty", {mem_dispatch_read_out, mem_dispatch_write_out}, 32'h0);
        idle(2);

        // Single read, latency to dispatch and to response.
        set_req(0, 1'b1, 1'b0, 16'h0010, 8'h00);
        expect_rsp(0, 16'h0010);
        sample();
        chk("rd_accept", 32'(req_accept_out), 32'h1);
        cyc_start();
        clr_req();
        sample();
        chk("rd_disp", {mem_dispatch_read_out, mem_dispatch_write_out, mem_addr_out}, {2'b10, 16'h0010});
        cyc_start();
        sample();
        chk("rd_rsp_early", 32'(rsp_valid_out), 32'h0);
        cyc_start();
        sample();
        chk("rd_rsp_valid", 32'(rsp_valid_out), 32'h1);
        chk("rd_rsp_data", 32'(rsp_data_out), 32'hA5);
        idle(3);

        // Back-pressure: dispatch held, no accepts; refill on the ready cycle.
        set_req(1, 1'b1, 1'b0, 16'h0040, 8'h00);
        expect_rsp(1, 16'h0040);
        sample();
        chk("stall_first_accept", 32'(req_accept_out), 32'h2);
        for (int i = 0; i < 3; i++) begin
            cyc_start();
            clr_req();
            set_req(0, 1'b0, 1'b1, 16'h0300, 8'h77);
            mem_ready_in = 1'b0;
            sample();
            chk("stall_accept", 32'(req_accept_out), 32'h0);
            chk("stall_hold", {mem_dispatch_read_out, mem_dispatch_write_out, mem_addr_out}, {2'b10, 16'h0040});
        end
        cyc_start();
        mem_ready_in = 1'b1;
        sample();
        chk("stall_release_accept", 32'(req_accept_out), 32'h1);
        chk("stall_release_disp", {mem_dispatch_read_out, mem_addr_out}, {1'b1, 16'h0040});
        cyc_start();
        clr_req();
        sample();
        chk("stall_next_disp", {mem_dispatch_write_out, mem_addr_out, mem_write_data_out}, {1'b1, 16'h0300, 8'h77});
        idle(4);

        // Back-to-back reads from requester 1 then 0.
        set_req(1, 1'b1, 1'b0, 16'h0001, 8'h00);
        set_req(0, 1'b1, 1'b0, 16'h0002, 8'h00);
        expect_rsp(1, 16'h0001);
        sample();
        chk("b2b_accept1", 32'(req_accept_out), 32'h2);
        cyc_start();
        req_read_in[1] = 1'b0;
        expect_rsp(0, 16'h0002);
        sample();
        chk("b2b_accept0", 32'(req_accept_out), 32'h1);
        cyc_start();
        clr_req();
        cyc_start();
        sample();
        chk("b2b_rsp1", {rsp_valid_out, rsp_data_out}, {2'b10, 8'h33});
        cyc_start();
        sample();
        chk("b2b_rsp0", {rsp_valid_out, rsp_data_out}, {2'b01, 8'h44});
        idle(3);

        // Read and write together from one requester is a write only.
        set_req(1, 1'b1, 1'b1, 16'h0500, 8'h99);
        sample();
        chk("rdwr_accept", 32'(req_accept_out), 32'h2);
        cyc_start();
        clr_req();
        sample();
        chk("rdwr_disp", {mem_dispatch_read_out, mem_dispatch_write_out, mem_addr_out, mem_write_data_out},
            {2'b01, 16'h0500, 8'h99});
        idle(4);

        // Reset right after a read is accepted: its data is never flagged.
        set_req(0, 1'b1, 1'b0, 16'h0050, 8'h00);
        sample();
        chk("rstmid_accept", 32'(req_accept_out), 32'h1);
        cyc_start();
        clr_req();
        req_write_in = 2'b11;
        rst_in = 1'b1;
        sample();
        chk("rstmid_accept_in_rst", 32'(req_accept_out), 32'h0);
        cyc_start();
        rst_in = 1'b0;
        set_req(0, 1'b0, 1'b1, 16'h0100, 8'h11);
        set_req(1, 1'b0, 1'b1, 16'h0200, 8'h22);
        sample();
        chk("rstmid_slot_empty", {mem_dispatch_read_out, mem_dispatch_write_out}, 32'h0);
        chk("rstmid_ptr_cleared", 32'(req_accept_out), 32'h1);
        for (int i = 0; i < 3; i++) begin
            cyc_start();
            clr_req();
            sample();
            chk("rstmid_no_rsp", 32'(rsp_valid_out), 32'h0);
        end
        idle(2);

        // Lone requester is granted every cycle.
        for (int k = 0; k < 4; k++) begin
            cyc_start();
            set_req(0, 1'b1, 1'b0, 16'h0060 + 16'(k), 8'h00);
            expect_rsp(0, 16'h0060 + 16'(k));
            sample();
            chk("single_accept", 32'(req_accept_out), 32'h1);
        end
        idle(8);
        sample();
        chk("sb_drained", 32'(sb_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single data-memory port among NUM_REQ requesters, e.g. cpu data port (req 0) and a DMA/video fetch engine (req 1).
- Round-robin grant; one registered dispatch slot toward memory with back-pressure via mem_ready_in.
- Tracks in-flight reads over a fixed memory read latency and routes returned data back to the requester that issued it.
- Sits between the requesters and the memory-side controller.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
ADDR_W, 16, address width
DATA_W, 8, data width
READ_LATENCY, 2, cycles from an accepted read dispatch to read data valid on mem_read_data_in (>=1)

Ports:
clk_in  input  1  clock; every register updates on its rising edge
rst_in  input  1  reset; synchronous, active-high
req_read_in  input  NUM_REQ  per-requester read request; held until accepted
req_write_in  input  NUM_REQ  per-requester write request; held until accepted
req_addr_in  input  NUM_REQ x ADDR_W  per-requester address
req_wdata_in  input  NUM_REQ x DATA_W  per-requester write data
req_accept_out  output  NUM_REQ  one-hot (or zero) combinational accept; request consumed at this edge
rsp_valid_out  output  NUM_REQ  one-hot (or zero) read-data-valid strobe
rsp_data_out  output  DATA_W  read data, broadcast to all requesters; qualified by rsp_valid_out
mem_addr_out  output  ADDR_W  registered memory address
mem_write_data_out  output  DATA_W  registered write data
mem_dispatch_read_out  output  1  registered read dispatch
mem_dispatch_write_out  output  1  registered write dispatch
mem_ready_in  input  1  memory consumes the current dispatch this cycle
mem_read_data_in  input  DATA_W  memory read data; valid READ_LATENCY cycles after an accepted read

Behaviour:
- Reset (rst_in high at an edge): RR pointer=0, dispatch slot empty (mem_dispatch_* =0, mem_addr_out=0, mem_write_data_out=0), tag pipeline cleared, so rsp_valid_out=0.
- Reset mid-operation: in-flight reads are dropped and their returning data is never flagged. Requesters re-issue after reset.
- During reset cycles req_accept_out=0.
- Slot can load when empty, or when full and mem_ready_in=1 (consumed this cycle).
- Grant: when the slot can load, the winner is the first requester at or after the RR pointer (cyclic) with read or write high.
- req_accept_out[winner]=1 in the same cycle. At the edge the slot loads addr, wdata and op, and the pointer becomes (winner+1) mod NUM_REQ.
- If no request is granted, the pointer is unchanged. If the slot is consumed and there is no new grant, the slot empties.
- Read and write both high from one requester: serviced as a write; the read is discarded. The requester must drop both.
- Dispatch held stable (addr/data/op) while mem_ready_in=0.
- Latency: request seen in cycle t, accepted at t. Dispatch visible at t+1 (minimum).
- Read accepted by memory in cycle c (dispatch_read=1, ready=1): mem_read_data_in valid in c+READ_LATENCY. In that cycle rsp_valid_out[id]=1, and rsp_data_out = mem_read_data_in combinationally.
- Tag pipeline: READ_LATENCY stages of {valid, id}, shifting every cycle. It supports one read per cycle back-to-back, with no stalls from read tracking.
- Writes are fire-and-forget; no response.
- Fairness: a continuously requesting requester waits at most NUM_REQ-1 grants.
- Single requester: granted every cycle the slot can load (full throughput when mem_ready_in=1).

Decomposition:
- Package mem_arb_pkg: req_id_t (logic [$clog2(NUM_REQ)-1:0] at package default), mem_op_e {OP_NONE, OP_READ, OP_WRITE}, and struct dispatch_t {op, addr, data}.
- Sub-module rr_picker: NUM_REQ-wide round-robin priority select from request vector and pointer. Outputs one-hot grant, encoded id and any_grant; purely combinational.
- Tag pipeline and dispatch register stay in mem_bus_arbiter.

Test Plan:
- Reset release, no requests → all outputs 0 for 10 cycles; pointer stays 0.
- Req0 read addr 0x0010, mem_ready=1, READ_LATENCY=2, memory returns 0xA5 → accept0 at cycle t. Dispatch_read with addr 0x0010 at t+1. rsp_valid_out=01 with rsp_data 0xA5 at t+3.
- Req0 and req1 both writing continuously (0x0100/0x11, 0x0200/0x22) → accepts alternate 0,1,0,1. Memory sees the alternating addr/data pairs every cycle.
- mem_ready_in=0 for 3 cycles with a read dispatch for addr 0x0040 pending → dispatch holds 0x0040, no accepts. On ready, the next grant loads the same cycle.
- Back-to-back reads req1 0x0001 then req0 0x0002, memory returns 0x33, 0x44 → rsp_valid 10 with 0x33, then 01 with 0x44, on consecutive cycles.
- Read accepted, rst_in asserted the next cycle for 1 cycle → no rsp_valid_out ever asserted for that read; the slot is empty after reset.
